// File: rtl/disassembly_display_sequencer_if.sv
// Bundles the start/status, instruction-fetch, disassembler and character-write
// signals of the display sequencer; master is the sequencer side.
interface disassembly_display_sequencer_if #(
  parameter int CHAR_ADDRESS_WIDTH = 9
);
  logic                          start;
  logic                          continuous;
  logic [31:0]                   baseAddress;
  logic                          busy;
  logic                          done;
  logic                          instructionRead;
  logic [31:0]                   instructionAddress;
  logic [31:0]                   instructionData;
  logic [31:0]                   disasmInstruction;
  logic [255:0]                  disasmText;
  logic                          charWrite;
  logic [CHAR_ADDRESS_WIDTH-1:0] charAddress;
  logic [7:0]                    charData;
  logic                          charReady;

  modport master (
    input  start, continuous, baseAddress, instructionData, disasmText, charReady,
    output busy, done, instructionRead, instructionAddress, disasmInstruction,
           charWrite, charAddress, charData
  );

  modport slave (
    output start, continuous, baseAddress, instructionData, disasmText, charReady,
    input  busy, done, instructionRead, instructionAddress, disasmInstruction,
           charWrite, charAddress, charData
  );
endinterface

// File: rtl/disassembly_display_sequencer.sv
// Fetches LINES consecutive instruction words, feeds each to an external
// combinational disassembler and streams its 32 characters into the display RAM.
module disassembly_display_sequencer #(
  parameter int LINES              = 16,
  parameter int CHAR_ADDRESS_WIDTH = 9
) (
  input  logic                            clock,
  input  logic                            reset,
  disassembly_display_sequencer_if.master bus
);

  localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_EMIT,
    ST_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [31:0]                   base_q, base_d;
  logic [31:0]                   addr_q, addr_d;
  logic [31:0]                   instr_q, instr_d;
  logic [LINE_W-1:0]             line_q, line_d;
  logic [4:0]                    col_q, col_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          read_q, read_d;
  logic                          write_q, write_d;
  logic [CHAR_ADDRESS_WIDTH-1:0] char_addr_q, char_addr_d;
  logic [7:0]                    char_raw;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      instr_q     <= '0;
      line_q      <= '0;
      col_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      char_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      line_q      <= line_d;
      col_q       <= col_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      read_q      <= read_d;
      write_q     <= write_d;
      char_addr_q <= char_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    line_d  = line_q;
    col_d   = col_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          base_d  = {bus.baseAddress[31:2], 2'b00};
          addr_d  = {bus.baseAddress[31:2], 2'b00};
          line_d  = '0;
          col_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        instr_d = bus.instructionData;
        col_d   = '0;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        // Nothing advances until the display buffer accepts the character.
        if (bus.charReady) begin
          if (col_q != 5'd31) begin
            col_d = col_q + 5'd1;
          end else if (line_q != LAST_LINE) begin
            line_d  = line_q + 1'b1;
            col_d   = '0;
            addr_d  = addr_q + 32'd4;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.continuous) begin
          addr_d  = base_q;
          line_d  = '0;
          col_d   = '0;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output flops are loaded from the next state so they line up with it.
  always_comb begin
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    read_d      = (state_d == ST_FETCH);
    write_d     = (state_d == ST_EMIT);
    char_addr_d = CHAR_ADDRESS_WIDTH'({line_d, col_d});
  end

  // Column c lives at bits 255-8c; {~c, 3'b111} is exactly that index.
  assign char_raw = bus.disasmText[{~col_q, 3'b111} -: 8];

  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.instructionRead    = read_q;
  assign bus.instructionAddress = addr_q;
  assign bus.disasmInstruction  = instr_q;
  assign bus.charWrite          = write_q;
  assign bus.charAddress        = char_addr_q;
  assign bus.charData           = write_q ? ((char_raw == 8'h00) ? 8'h20 : char_raw) : 8'h00;

endmodule

// File: tb/tb_disassembly_display_sequencer.sv
// Directed bench for disassembly_display_sequencer with a transaction-level
// model of the expected reads and character writes for each refresh.
module tb_disassembly_display_sequencer;

  localparam int LINES = 2;
  localparam int CAW   = 9;

  typedef struct {
    logic [CAW-1:0] addr;
    logic [7:0]     data;
  } wr_t;

  logic clock;
  logic reset;

  disassembly_display_sequencer_if #(.CHAR_ADDRESS_WIDTH(CAW)) bus ();

  disassembly_display_sequencer #(
    .LINES(LINES),
    .CHAR_ADDRESS_WIDTH(CAW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.master)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  bit          active = 0;
  logic [31:0] model_base;
  int          t_ref;
  int          stalls;
  int          n_writes;
  int          done_count = 0;
  int          last_done_rel;
  int          done_abs;
  logic [31:0] exp_reads[$];
  wr_t         exp_writes[$];
  logic [31:0] read_log[$];
  int          read_cyc[$];
  logic [7:0]  char_log[0:63];

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] str_text(input string s);
    logic [255:0] t;
    t = '0;
    for (int i = 0; i < s.len() && i < 32; i++) t[255-8*i -: 8] = s[i];
    return t;
  endfunction

  function automatic logic [255:0] padded(input string s);
    logic [255:0] t;
    t = {32{8'h20}};
    for (int i = 0; i < s.len() && i < 32; i++) t[255-8*i -: 8] = s[i];
    return t;
  endfunction

  // Stand-in for the external Disassembler: a few known words, letters otherwise.
  function automatic logic [255:0] dtext(input logic [31:0] w);
    logic [255:0] t;
    t = '0;
    case (w)
      32'h0000_0000: t = str_text("nop");
      32'h2008_0005: t = str_text("addi    $8,     $0,     0x0005  ");
      32'hFC00_0000: t = str_text("<unknown>");
      default: begin
        for (int c = 0; c < 32; c++) t[255-8*c -: 8] = 8'h41 + 8'((int'(w[7:0]) + c) % 26);
      end
    endcase
    return t;
  endfunction

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0000_0000;
      32'h0000_0104: return 32'h2008_0005;
      32'hFFFF_FFFC: return 32'hFC00_0000;
      32'h0000_0000: return 32'h1234_5601;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  function automatic logic [255:0] line_text(input int line);
    logic [255:0] t;
    for (int c = 0; c < 32; c++) t[255-8*c -: 8] = char_log[line*32+c];
    return t;
  endfunction

  task automatic build_expect(input logic [31:0] base);
    logic [31:0]  a;
    logic [255:0] t;
    wr_t          w;
    exp_reads.delete();
    exp_writes.delete();
    a = base;
    for (int l = 0; l < LINES; l++) begin
      exp_reads.push_back(a);
      t = dtext(mem(a));
      for (int c = 0; c < 32; c++) begin
        w.addr = CAW'(l*32 + c);
        w.data = t[255-8*c -: 8];
        if (w.data == 8'h00) w.data = 8'h20;
        exp_writes.push_back(w);
      end
      a = a + 32'd4;
    end
  endtask

  // Memory answers one cycle after the strobe, garbage at all other times.
  always @(negedge clock) begin
    logic [31:0] a;
    if (!reset && bus.instructionRead) begin
      a = bus.instructionAddress;
      @(posedge clock);
      #1 bus.instructionData = mem(a);
      @(posedge clock);
      #1 bus.instructionData = 32'hDEAD_BEEF;
    end
  end

  assign bus.disasmText = dtext(bus.disasmInstruction);

  always @(negedge clock) begin
    bit  was_active;
    int  rel;
    wr_t w;
    if (reset) begin
      active = 0;
      exp_reads.delete();
      exp_writes.delete();
    end else begin
      was_active = active;
      check_output("busy", bus.busy, was_active);
      if (!was_active) begin
        check_output("idle_quiet", {bus.instructionRead, bus.charWrite, bus.done}, 0);
      end else begin
        rel = cyc - t_ref + 1;
        if (bus.instructionRead) begin
          read_log.push_back(bus.instructionAddress);
          read_cyc.push_back(cyc);
          check_output("read_pending", exp_reads.size() > 0, 1);
          if (exp_reads.size() > 0) begin
            check_output("read_addr", bus.instructionAddress, exp_reads.pop_front());
          end
        end
        if (bus.charWrite && bus.charReady) begin
          if (int'(bus.charAddress) < 64) char_log[bus.charAddress] = bus.charData;
          n_writes++;
          check_output("write_pending", exp_writes.size() > 0, 1);
          if (exp_writes.size() > 0) begin
            w = exp_writes.pop_front();
            check_output("char_write", {bus.charAddress, bus.charData}, {w.addr, w.data});
          end
        end
        if (bus.charWrite && !bus.charReady) stalls++;
        if (bus.done) begin
          check_output("done_queues_empty", exp_reads.size() + exp_writes.size(), 0);
          check_output("done_cycle", rel, 34*LINES + 1 + stalls);
          last_done_rel = rel;
          done_abs = cyc;
          done_count++;
          if (bus.continuous) begin
            build_expect(model_base);
            t_ref    = cyc + 1;
            stalls   = 0;
            n_writes = 0;
          end else begin
            active = 0;
          end
        end
      end
      if (!was_active && bus.start) begin
        model_base = {bus.baseAddress[31:2], 2'b00};
        build_expect(model_base);
        t_ref    = cyc + 1;
        stalls   = 0;
        n_writes = 0;
        read_log.delete();
        read_cyc.delete();
        for (int i = 0; i < 64; i++) char_log[i] = 8'h00;
        active = 1;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic [31:0] base, input logic cont);
    bus.baseAddress = base;
    bus.continuous  = cont;
    bus.start       = 1'b1;
    step();
    bus.start       = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0;
    bit seen;
    n0   = done_count;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (done_count != n0) seen = 1;
    end
    check_output("done_seen", seen, 1);
  endtask

  task automatic wait_char(input int addr, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (bus.charWrite && int'(bus.charAddress) == addr) seen = 1;
      else step();
    end
    check_output("char_reached", seen, 1);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clock               = 1'b0;
    reset               = 1'b1;
    bus.start           = 1'b0;
    bus.continuous      = 1'b0;
    bus.baseAddress     = '0;
    bus.charReady       = 1'b1;
    bus.instructionData = '0;
    repeat (3) step();
    reset = 1'b0;
    check_output("reset_state", {bus.busy, bus.done, bus.instructionRead, bus.instructionAddress,
                                 bus.disasmInstruction, bus.charWrite, bus.charAddress, bus.charData}, 0);
    step();

    // Basic refresh of two lines.
    apply_stimulus(32'h0000_0100, 1'b0);
    wait_done(300);
    check_output("basic_done_cycle", last_done_rel, 69);
    check_output("basic_write_count", n_writes, 64);
    check_output("basic_read0", read_log.size() > 0 ? read_log[0] : 32'hFFFF_FFFF, 32'h0000_0100);
    check_output("basic_read1", read_log.size() > 1 ? read_log[1] : 32'hFFFF_FFFF, 32'h0000_0104);
    check_output("basic_line0", line_text(0), padded("nop"));
    check_output("basic_line1", line_text(1), padded("addi    $8,     $0,     0x0005  "));
    check_output("null_as_space", char_log[3], 8'h20);
    step();
    check_output("basic_idle_after", bus.busy, 0);

    // Three-cycle back-pressure at column 10 of line 0.
    apply_stimulus(32'h0000_0100, 1'b0);
    wait_char(10, 50);
    bus.charReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_output("stall_addr", bus.charAddress, 10);
      check_output("stall_data", bus.charData, 8'h20);
      step();
    end
    bus.charReady = 1'b1;
    wait_done(300);
    check_output("stall_done_cycle", last_done_rel, 72);
    check_output("stall_write_count", n_writes, 64);
    check_output("stall_cycles", stalls, 3);
    check_output("stall_line1", line_text(1), padded("addi    $8,     $0,     0x0005  "));
    step();

    // Address wrap and unaligned base.
    apply_stimulus(32'hFFFF_FFFC, 1'b0);
    wait_done(300);
    check_output("wrap_read0", read_log.size() > 0 ? read_log[0] : 32'h1, 32'hFFFF_FFFC);
    check_output("wrap_read1", read_log.size() > 1 ? read_log[1] : 32'h1, 32'h0000_0000);
    check_output("unknown_line", line_text(0), padded("<unknown>"));
    step();
    apply_stimulus(32'h0000_0103, 1'b0);
    wait_done(300);
    check_output("unaligned_read0", read_log.size() > 0 ? read_log[0] : 32'h1, 32'h0000_0100);
    step();

    // Ignored start while busy, then continuous restart and its release.
    apply_stimulus(32'h0000_0100, 1'b1);
    repeat (10) step();
    bus.baseAddress = 32'hFFFF_FFFC;
    bus.start       = 1'b1;
    step();
    bus.start       = 1'b0;
    wait_done(300);
    for (int i = 0; i < 5 && read_log.size() < 3; i++) step();
    check_output("cont_read_addr", read_log.size() > 2 ? read_log[2] : 32'h1, 32'h0000_0100);
    check_output("cont_read_cycle", read_cyc.size() > 2 ? read_cyc[2] : 0, done_abs + 1);
    bus.continuous = 1'b0;
    wait_done(300);
    check_output("cont_second_done", last_done_rel, 69);
    step();
    check_output("cont_release_idle", bus.busy, 0);

    // Reset in the middle of line 1, column 5, then a clean restart.
    apply_stimulus(32'h0000_0100, 1'b0);
    wait_char(37, 100);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_output("midreset_outputs", {bus.busy, bus.done, bus.instructionRead, bus.instructionAddress,
                                      bus.disasmInstruction, bus.charWrite, bus.charAddress, bus.charData}, 0);
    step();
    apply_stimulus(32'h0000_0100, 1'b0);
    check_output("restart_fetch", {bus.instructionRead, bus.instructionAddress}, {1'b1, 32'h0000_0100});
    wait_done(300);
    check_output("restart_done_cycle", last_done_rel, 69);
    check_output("restart_write_count", n_writes, 64);
    check_output("restart_line0", line_text(0), padded("nop"));
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
